// File: rtl/pc_redirect_pkg.sv
// Shared constants for the PC redirect controller.
// - PC mux select codes (PC+4, branch, jump, JR).
// - FSM state encoding.
// - JR load-use wait counts: a load in EX needs 2 cycles before its result is
//   forwardable to ID, a load in MEM needs 1.
package pc_redirect_pkg;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_BR  = 2'b01;
    localparam logic [1:0] PCSEL_J   = 2'b10;
    localparam logic [1:0] PCSEL_JR  = 2'b11;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StJrWait   = 2'd1,
        StRedirect = 2'd2
    } state_e;

    localparam logic [1:0] WAIT_EX  = 2'd2;
    localparam logic [1:0] WAIT_MEM = 2'd1;

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Bus between ID-stage decode/control and the PC redirect controller.
// master: decode/hazard side (drives requests, targets, load info, stall_i).
// slave : pc_redirect_ctrl (drives pc_sel, redirect_pc, write enables,
//         flush/bubble and the conflict pulse).
// Optional macro PC_REDIRECT_STATS_EN adds redirect_cnt and jr_stall_cnt.
interface pc_redirect_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned REG_AW = 5
);
    logic              stall_i;
    logic              jr_req;
    logic [ADDR_W-1:0] jr_target;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              j_req;
    logic [ADDR_W-1:0] j_target;
    logic [REG_AW-1:0] id_rs;
    logic              ex_memread;
    logic [REG_AW-1:0] ex_rd;
    logic              mem_memread;
    logic [REG_AW-1:0] mem_rd;

    logic [1:0]        pc_sel;
    logic [ADDR_W-1:0] redirect_pc;
    logic              pc_write;
    logic              ifid_write;
    logic              flush_ifid;
    logic              bubble_idex;
    logic              conflict;
`ifdef PC_REDIRECT_STATS_EN
    logic [15:0]       redirect_cnt;
    logic [15:0]       jr_stall_cnt;
`endif

    modport master (
        output stall_i, jr_req, jr_target, br_taken, br_target, j_req, j_target,
        output id_rs, ex_memread, ex_rd, mem_memread, mem_rd,
        input  pc_sel, redirect_pc, pc_write, ifid_write, flush_ifid, bubble_idex,
        input  conflict
`ifdef PC_REDIRECT_STATS_EN
        ,
        input  redirect_cnt, jr_stall_cnt
`endif
    );

    modport slave (
        input  stall_i, jr_req, jr_target, br_taken, br_target, j_req, j_target,
        input  id_rs, ex_memread, ex_rd, mem_memread, mem_rd,
        output pc_sel, redirect_pc, pc_write, ifid_write, flush_ifid, bubble_idex,
        output conflict
`ifdef PC_REDIRECT_STATS_EN
        ,
        output redirect_cnt, jr_stall_cnt
`endif
    );

endinterface

// File: rtl/jr_hazard_detect.sv
// Combinational JR load-use hazard check.
// Ports: i_jr_req, i_id_rs, i_ex_memread/i_ex_rd, i_mem_memread/i_mem_rd in;
//        o_hazard (JR must wait), o_wait_cnt (cycles until rs is forwardable).
// A load in EX dominates one in MEM since it is the younger producer.
module jr_hazard_detect
    import pc_redirect_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              i_jr_req,
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic              i_ex_memread,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_mem_memread,
    input  logic [REG_AW-1:0] i_mem_rd,
    output logic              o_hazard,
    output logic [1:0]        o_wait_cnt
);

    logic w_rs_nonzero;
    logic w_ex_hit;
    logic w_mem_hit;

    always_comb begin
        w_rs_nonzero = (i_id_rs != '0);
        w_ex_hit     = i_jr_req && w_rs_nonzero && i_ex_memread && (i_ex_rd == i_id_rs);
        w_mem_hit    = i_jr_req && w_rs_nonzero && i_mem_memread && (i_mem_rd == i_id_rs);
        o_hazard     = w_ex_hit || w_mem_hit;
        if (w_ex_hit) begin
            o_wait_cnt = WAIT_EX;
        end else if (w_mem_hit) begin
            o_wait_cnt = WAIT_MEM;
        end else begin
            o_wait_cnt = 2'd0;
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Sequences ID-resolved control-flow redirects (JR > branch > jump).
// Ports: clk, reset (async, active-high), bus (pc_redirect_ctrl_if.slave):
//   requests/targets/load info/stall_i in; pc_sel, redirect_pc, pc_write,
//   ifid_write, flush_ifid, bubble_idex, conflict out.
// Optional macro PC_REDIRECT_STATS_EN adds saturating redirect_cnt (commits)
// and jr_stall_cnt (JR_WAIT cycles) on the bus.
module pc_redirect_ctrl
    import pc_redirect_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input logic               clk,
    input logic               reset,
    pc_redirect_ctrl_if.slave bus
);

    state_e            r_state, w_state_next;
    logic [1:0]        r_wait_cnt, w_wait_cnt_next;
    logic [1:0]        r_pc_sel, w_pc_sel_next;
    logic [ADDR_W-1:0] r_redirect_pc, w_redirect_pc_next;
    logic              r_conflict, w_conflict_next;

    logic              w_pc_write;
    logic              w_ifid_write;
    logic              w_flush_ifid;
    logic              w_bubble_idex;
    logic              w_any_req;
    logic              w_multi_req;
    logic              w_jr_hazard;
    logic [1:0]        w_jr_wait_init;

    jr_hazard_detect #(
        .REG_AW (REG_AW)
    ) u_jr_hazard_detect (
        .i_jr_req      (bus.jr_req),
        .i_id_rs       (bus.id_rs),
        .i_ex_memread  (bus.ex_memread),
        .i_ex_rd       (bus.ex_rd),
        .i_mem_memread (bus.mem_memread),
        .i_mem_rd      (bus.mem_rd),
        .o_hazard      (w_jr_hazard),
        .o_wait_cnt    (w_jr_wait_init)
    );

    assign w_any_req   = bus.jr_req || bus.br_taken || bus.j_req;
    assign w_multi_req = (bus.jr_req && bus.br_taken) || (bus.jr_req && bus.j_req) ||
                         (bus.br_taken && bus.j_req);

    always_comb begin
        w_state_next       = r_state;
        w_wait_cnt_next    = r_wait_cnt;
        w_pc_sel_next      = r_pc_sel;
        w_redirect_pc_next = r_redirect_pc;
        w_conflict_next    = 1'b0;
        w_pc_write         = 1'b1;
        w_ifid_write       = 1'b1;
        w_flush_ifid       = 1'b0;
        w_bubble_idex      = 1'b0;

        case (r_state)
            StIdle: begin
                // Stalled requests stay on the inputs and are taken once stall_i drops.
                if (!bus.stall_i && w_any_req) begin
                    w_conflict_next = w_multi_req;
                    w_pc_write      = 1'b0;
                    if (w_jr_hazard) begin
                        w_ifid_write    = 1'b0;
                        w_bubble_idex   = 1'b1;
                        w_wait_cnt_next = w_jr_wait_init;
                        w_state_next    = StJrWait;
                    end else begin
                        w_state_next = StRedirect;
                        if (bus.jr_req) begin
                            w_pc_sel_next      = PCSEL_JR;
                            w_redirect_pc_next = bus.jr_target;
                        end else if (bus.br_taken) begin
                            w_pc_sel_next      = PCSEL_BR;
                            w_redirect_pc_next = bus.br_target;
                        end else begin
                            w_pc_sel_next      = PCSEL_J;
                            w_redirect_pc_next = bus.j_target;
                        end
                    end
                end
            end
            StJrWait: begin
                w_pc_write    = 1'b0;
                w_ifid_write  = 1'b0;
                w_bubble_idex = 1'b1;
                if (!bus.stall_i) begin
                    // Last wait cycle: the forwarded rs value is valid now.
                    if (r_wait_cnt <= 2'd1) begin
                        w_wait_cnt_next    = 2'd0;
                        w_pc_sel_next      = PCSEL_JR;
                        w_redirect_pc_next = bus.jr_target;
                        w_state_next       = StRedirect;
                    end else begin
                        w_wait_cnt_next = r_wait_cnt - 2'd1;
                    end
                end
            end
            StRedirect: begin
                w_flush_ifid = 1'b1;
                if (!bus.stall_i) begin
                    w_pc_sel_next = PCSEL_SEQ;
                    w_state_next  = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= StIdle;
            r_wait_cnt    <= 2'd0;
            r_pc_sel      <= PCSEL_SEQ;
            r_redirect_pc <= '0;
            r_conflict    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_wait_cnt    <= w_wait_cnt_next;
            r_pc_sel      <= w_pc_sel_next;
            r_redirect_pc <= w_redirect_pc_next;
            r_conflict    <= w_conflict_next;
        end
    end

    assign bus.pc_sel      = r_pc_sel;
    assign bus.redirect_pc = r_redirect_pc;
    assign bus.conflict    = r_conflict;
    assign bus.pc_write    = w_pc_write;
    assign bus.ifid_write  = w_ifid_write;
    assign bus.flush_ifid  = w_flush_ifid;
    assign bus.bubble_idex = w_bubble_idex;

`ifdef PC_REDIRECT_STATS_EN
    logic [15:0] r_redirect_cnt;
    logic [15:0] r_jr_stall_cnt;
    logic        w_commit;

    assign w_commit = (r_state == StRedirect) && !bus.stall_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_redirect_cnt <= 16'd0;
            r_jr_stall_cnt <= 16'd0;
        end else begin
            if (w_commit && (r_redirect_cnt != 16'hFFFF)) begin
                r_redirect_cnt <= r_redirect_cnt + 16'd1;
            end
            if ((r_state == StJrWait) && (r_jr_stall_cnt != 16'hFFFF)) begin
                r_jr_stall_cnt <= r_jr_stall_cnt + 16'd1;
            end
        end
    end

    assign bus.redirect_cnt = r_redirect_cnt;
    assign bus.jr_stall_cnt = r_jr_stall_cnt;
`endif

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Sequences every control-flow redirect of the 5-stage pipeline: register-indirect jumps, taken branches and direct jumps, all resolved in ID. Arbitrates simultaneous redirect requests and stalls on a JR load-use hazard until the rs operand is forwardable. Drives the PC mux select, PC/IF-ID write enables, the IF/ID flush and the ID/EX bubble. Sits between the ID-stage decode and control logic and the fetch stage.

Parameters:
ADDR_W, 32, PC/target width
REG_AW, 5, register-file address width

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-high reset
stall_i  in  1  external pipeline stall from the hazard unit; freezes this block
jr_req  in  1  ID instruction is JR (JRControl)
jr_target  in  ADDR_W  forwarded rs value
br_taken  in  1  ID branch resolved taken
br_target  in  ADDR_W  branch target
j_req  in  1  ID instruction is J/JAL
j_target  in  ADDR_W  jump target
id_rs  in  REG_AW  rs field of the ID instruction
ex_memread  in  1  ID/EX instruction is a load
ex_rd  in  REG_AW  ID/EX destination register
mem_memread  in  1  EX/MEM instruction is a load
mem_rd  in  REG_AW  EX/MEM destination register
pc_sel  out  2  00 PC+4, 01 branch, 10 jump, 11 JR
redirect_pc  out  ADDR_W  registered target
pc_write  out  1  PC write enable
ifid_write  out  1  IF/ID write enable
flush_ifid  out  1  squash IF/ID
bubble_idex  out  1  insert NOP into ID/EX
conflict  out  1  one-cycle pulse: more than one request in the same cycle

Behaviour:
- Reset: asynchronous, active-high. State IDLE, wait_cnt=0, pc_sel=00, redirect_pc=0, pc_write=1, ifid_write=1, flush_ifid=0, bubble_idex=0, conflict=0. Reset mid-operation abandons any pending redirect.
- States: IDLE, JR_WAIT, REDIRECT.
- IDLE, stall_i=1: requests ignored; state held. The stalled requests persist and are accepted once stall_i drops.
- IDLE, stall_i=0, any request:
  - Priority JR > branch > jump. conflict is registered high for one cycle when 2 or more requests are asserted.
  - JR hazard when id_rs!=0 and either (ex_memread and ex_rd==id_rs), giving wait_cnt=2, or (mem_memread and mem_rd==id_rs), giving wait_cnt=1. The EX match takes precedence.
  - JR with hazard: go to JR_WAIT with pc_write=0, ifid_write=0, bubble_idex=1.
  - Otherwise: latch the winner's target into redirect_pc, latch its pc_sel code, set pc_write=0 this cycle, go to REDIRECT.
- JR_WAIT:
  - pc_write=0, ifid_write=0, bubble_idex=1.
  - wait_cnt decrements only while stall_i=0.
  - When it reaches 0: latch jr_target and pc_sel=11, then go to REDIRECT.
  - br/j requests are ignored in this state.
- REDIRECT:
  - pc_sel and redirect_pc are valid, flush_ifid=1, pc_write=1.
  - If stall_i=1: hold all outputs and state.
  - The first cycle with stall_i=0 commits the redirect; next state IDLE with pc_sel returning to 00.
  - Requests arriving in REDIRECT are ignored, because their instruction is being flushed.
- Latency: request (no hazard, no stall) in cycle N produces redirect outputs in N+1 and the target fetched in N+2. JR with EX-load hazard adds 2 cycles.
- Targets pass through unmodified; no arithmetic is performed on them.

Optional Feature:
PC_REDIRECT_STATS_EN:
- Defined: adds outputs redirect_cnt[15:0] and jr_stall_cnt[15:0].
  - redirect_cnt increments on each REDIRECT commit.
  - jr_stall_cnt increments on each JR_WAIT cycle.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the counters and their ports are absent; all other behaviour is identical.

Decomposition:
- Package pc_redirect_pkg holds:
  - the PCSEL_SEQ/BR/J/JR 2-bit localparams;
  - the state encoding (IDLE/JR_WAIT/REDIRECT);
  - the wait-count constants WAIT_EX=2 and WAIT_MEM=1.
- One natural sub-module, jr_hazard_detect: combinational; takes id_rs, ex/mem load info and jr_req; produces the hazard flag and initial wait_cnt.

Test Plan:
- j_req=1, j_target=0x00400100, no stall -> cycle N+1: pc_sel=10, redirect_pc=0x00400100, flush_ifid=1; cycle N+2: IDLE, pc_sel=00.
- jr_req=1, id_rs=8, ex_memread=1, ex_rd=8 -> 2 cycles of pc_write=0/bubble_idex=1, then pc_sel=11 with the jr_target value presented on the final wait cycle.
- jr_req=1, id_rs=8, mem_memread=1, mem_rd=8 -> exactly 1 wait cycle; with id_rs=0 and matching ex_rd=0 -> no wait.
- jr_req=1, br_taken=1, j_req=1 together -> pc_sel=11, JR target chosen, conflict=1 for one cycle.
- Branch in REDIRECT with stall_i high for 3 cycles -> outputs held for 3 cycles, commit on the 4th cycle, single flush sequence.
- reset asserted during JR_WAIT -> immediate IDLE, all outputs at reset values; with PC_REDIRECT_STATS_EN, counters cleared to 0.
